// File: rtl/layer_buf_pkg.sv
// Shared defaults, bank-state type and segment helper for the inter-layer
// feature-map buffer.
package layer_buf_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_SEG_LEN = 25;
    localparam int DEF_WORDS   = 400;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_e;

    function automatic int seg_count(input int words, input int seg_len);
        return (words + seg_len - 1) / seg_len;
    endfunction

endpackage

// File: rtl/layer_fmap_pingpong_buf_if.sv
// Producer/consumer bus of the feature-map buffer. The slave modport is the
// buffer side. The master modport is the layer (or bench) side.
interface layer_fmap_pingpong_buf_if #(
    parameter int DATA_W  = layer_buf_pkg::DEF_DATA_W,
    parameter int SEG_LEN = layer_buf_pkg::DEF_SEG_LEN
) ();

    logic                      wr_en_in;
    logic [31:0]               wr_addr_in;
    logic [DATA_W-1:0]         wr_data_in;
    logic                      prod_done;
    logic                      prod_ready;
    logic [31:0]               rd_addr_in;
    logic [DATA_W*SEG_LEN-1:0] rd_data_out;
    logic                      cons_en;
    logic                      cons_done;
    logic                      buf_err;

    modport master (
        output wr_en_in, wr_addr_in, wr_data_in, prod_done, rd_addr_in, cons_done,
        input  prod_ready, rd_data_out, cons_en, buf_err
    );

    modport slave (
        input  wr_en_in, wr_addr_in, wr_data_in, prod_done, rd_addr_in, cons_done,
        output prod_ready, rd_data_out, cons_en, buf_err
    );

endinterface

// File: rtl/fmap_seg_bank.sv
// One feature-map bank: a single-word write port and a registered segment
// read port that returns SEG_LEN words, zero-filled past WORDS.
module fmap_seg_bank
    import layer_buf_pkg::*;
#(
    parameter int WORDS   = DEF_WORDS,
    parameter int SEG_LEN = DEF_SEG_LEN,
    parameter int SEG_NUM = seg_count(WORDS, SEG_LEN),
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [$clog2(WORDS)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [31:0]                rd_seg,
    output logic [DATA_W*SEG_LEN-1:0]  rd_data
);

    localparam int AW = $clog2(WORDS);

    logic [DATA_W-1:0]         mem [WORDS];
    logic [DATA_W*SEG_LEN-1:0] seg_words;
    logic [31:0]               rd_base;

    function automatic logic [AW-1:0] low_addr(input logic [31:0] a);
        return a[AW-1:0];
    endfunction

    // NOTE: the storage array has no reset branch; a reset would turn it into
    // thousands of resettable flops instead of RAM, and stale words are legal.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_base = rd_seg * 32'(SEG_LEN);

    // NOTE: every variable written here gets its default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        seg_words = '0;
        for (int k = 0; k < SEG_LEN; k++) begin
            if (rd_seg < 32'(SEG_NUM) && (rd_base + 32'(k)) < 32'(WORDS))
                seg_words[k*DATA_W +: DATA_W] = mem[low_addr(rd_base + 32'(k))];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= seg_words;
    end

endmodule

// File: rtl/layer_fmap_pingpong_buf.sv
// Inter-layer feature-map buffer with done/enable bank handover.
// FMAP_BUF_PINGPONG_EN selects two banks; otherwise one bank is used.
module layer_fmap_pingpong_buf
    import layer_buf_pkg::*;
#(
    parameter int WORDS   = DEF_WORDS,
    parameter int SEG_LEN = DEF_SEG_LEN,
    parameter int SEG_NUM = seg_count(WORDS, SEG_LEN),
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    layer_fmap_pingpong_buf_if.slave   bus
);

    localparam int AW = $clog2(WORDS);

    logic prod_d_q, cons_d_q, prod_rise_q, cons_rise_q;
    logic prod_ready_q, cons_en_q, buf_err_q;
    logic seal, rel, wr_ok, wr_bad;
    logic ready_n, cons_n;

    // Handover events act only while the corresponding side owns a bank.
    assign seal   = prod_rise_q && prod_ready_q;
    assign rel    = cons_rise_q && cons_en_q;
    assign wr_ok  = bus.wr_en_in && prod_ready_q && (bus.wr_addr_in < 32'(WORDS));
    assign wr_bad = bus.wr_en_in && !wr_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_d_q     <= 1'b0;
            cons_d_q     <= 1'b0;
            prod_rise_q  <= 1'b0;
            cons_rise_q  <= 1'b0;
            prod_ready_q <= 1'b1;
            cons_en_q    <= 1'b0;
            buf_err_q    <= 1'b0;
        end else begin
            prod_d_q     <= bus.prod_done;
            cons_d_q     <= bus.cons_done;
            prod_rise_q  <= bus.prod_done && !prod_d_q;
            cons_rise_q  <= bus.cons_done && !cons_d_q;
            prod_ready_q <= ready_n;
            // One-cycle gap after a release lets the consumer rearm its counters.
            cons_en_q    <= cons_n && !rel;
            if (wr_bad) buf_err_q <= 1'b1;
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.cons_en    = cons_en_q;
    assign bus.buf_err    = buf_err_q;

`ifdef FMAP_BUF_PINGPONG_EN
    bank_state_e               st_q [2];
    bank_state_e               st_n [2];
    logic                      wr_bank_q, rd_bank_q, rd_sel_q;
    logic                      wr_bank_n, rd_bank_n;
    logic [DATA_W*SEG_LEN-1:0] rd_data [2];

    // Seal and release always hit different banks, so both apply together.
    always_comb begin
        st_n      = st_q;
        wr_bank_n = wr_bank_q;
        rd_bank_n = rd_bank_q;
        if (seal) begin
            st_n[wr_bank_q] = FULL;
            wr_bank_n       = !wr_bank_q;
        end
        if (rel) begin
            st_n[rd_bank_q] = EMPTY;
            rd_bank_n       = !rd_bank_q;
        end
        ready_n = (st_n[wr_bank_n] == EMPTY);
        cons_n  = (st_n[rd_bank_n] == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q      <= '{EMPTY, EMPTY};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            st_q      <= st_n;
            wr_bank_q <= wr_bank_n;
            rd_bank_q <= rd_bank_n;
            rd_sel_q  <= rd_bank_q;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fmap_seg_bank #(
            .WORDS   (WORDS),
            .SEG_LEN (SEG_LEN),
            .SEG_NUM (SEG_NUM),
            .DATA_W  (DATA_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we      (wr_ok && (wr_bank_q == 1'(b))),
            .waddr   (bus.wr_addr_in[AW-1:0]),
            .wdata   (bus.wr_data_in),
            .rd_seg  (bus.rd_addr_in),
            .rd_data (rd_data[b])
        );
    end

    // rd_sel_q tracks the bank that was read when the segment was registered.
    assign bus.rd_data_out = rd_data[rd_sel_q];
`else
    bank_state_e st_q, st_n;

    always_comb begin
        st_n = st_q;
        if (seal) st_n = FULL;
        if (rel)  st_n = EMPTY;
        ready_n = (st_n == EMPTY);
        cons_n  = (st_n == FULL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) st_q <= EMPTY;
        else        st_q <= st_n;
    end

    fmap_seg_bank #(
        .WORDS   (WORDS),
        .SEG_LEN (SEG_LEN),
        .SEG_NUM (SEG_NUM),
        .DATA_W  (DATA_W)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_ok),
        .waddr   (bus.wr_addr_in[AW-1:0]),
        .wdata   (bus.wr_data_in),
        .rd_seg  (bus.rd_addr_in),
        .rd_data (bus.rd_data_out)
    );
`endif

endmodule
